// File: rtl/alu_pkg.sv
// Purpose: shared types for the ALU control / multiply-divide block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: alu_ctrl_t ALU op codes, alu_option and funct codes, MDU state and op
// enums, and the packed decode record. The MDU_DIV_EN macro is consumed by the RTL files.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_NOP  = 4'b1111
    } alu_ctrl_t;

    localparam logic [1:0] OPT_ADD   = 2'b00;
    localparam logic [1:0] OPT_SUB   = 2'b01;
    localparam logic [1:0] OPT_RTYPE = 2'b10;
    localparam logic [1:0] OPT_OR    = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} mdu_state_t;
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} mdu_op_t;

    // One decoded instruction: ALU op plus MDU side-band flags.
    typedef struct packed {
        alu_ctrl_t ctrl;
        logic      undef;   // funct not recognised
        logic      mdu;     // any MDU funct (can be stalled by busy)
        logic      mf;      // mfhi or mflo
        logic      mf_hi;   // mfhi (else mflo)
        logic      start;   // mult/multu/div/divu
        mdu_op_t   op;
    } dec_t;

endpackage

// File: rtl/mdu_seq.sv
// Purpose: iterative radix-2 multiply / restoring divide sequencer owning HI and LO.
// Latency: start in cycle 0, busy cycles 1..WIDTH+1, HI/LO updated for cycle WIDTH+2.
// Backpressure: start is ignored while busy; the caller must hold and re-present it.
// Ports: clk, reset (sync, active-high), start/op/src_a/src_b issue, busy, hi, lo.
// Config: MDU_DIV_EN adds the DIV state and divide datapath; otherwise only mult/multu run.
module mdu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;    // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;    // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] opnd;      // |multiplicand| or |divisor|
    logic             neg_lo;    // negate product (mult) or quotient (div) in FIX

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MDU_DIV_EN
    logic           neg_hi;      // remainder takes the dividend's sign
    logic           fix_div;     // FIX applies divide correction rather than product
    logic [WIDTH:0] div_sh, div_diff;
    logic           div_ge;
`endif

    always_comb begin
        a_neg    = ((op == OP_MULT) || (op == OP_DIV)) && src_a[WIDTH-1];
        b_neg    = ((op == OP_MULT) || (op == OP_DIV)) && src_b[WIDTH-1];
        mag_a    = a_neg ? -src_a : src_a;
        mag_b    = b_neg ? -src_b : src_b;
        // Add multiplicand into the high half when the current multiplier bit is set;
        // the carry bit is shifted back in on the right shift.
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        div_ge   = (div_sh >= {1'b0, opnd});
        if (fix_div) begin
            fix_hi = neg_hi ? -acc_hi : acc_hi;
            fix_lo = neg_lo ? -acc_lo : acc_lo;
        end
`endif
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDU_DIV_EN
            neg_hi  <= 1'b0;
            fix_div <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc_hi <= '0;
                        cnt    <= '0;
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc_lo <= mag_b;
                                opnd   <= mag_a;
                                neg_lo <= a_neg ^ b_neg;
                                state  <= ST_MUL;
`ifdef MDU_DIV_EN
                                fix_div <= 1'b0;
`endif
                            end
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                acc_lo  <= mag_a;
                                opnd    <= mag_b;
                                // Divide by zero: quotient stays all ones, and the
                                // remainder ends as |a| which the sign fix turns into a.
                                neg_lo  <= (a_neg ^ b_neg) && (src_b != '0);
                                neg_hi  <= a_neg;
                                fix_div <= 1'b1;
                                state   <= ST_DIV;
                            end
`endif
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef MDU_DIV_EN
                ST_DIV: begin
                    acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// Purpose: ALU op decode from alu_option/funct, plus MDU issue, stall and HI/LO read mux.
// Latency: decode and mfhi/mflo read are combinational; MDU results land WIDTH+2 cycles after issue.
// Backpressure: stall is raised for any MDU funct while busy; the stalled start is dropped, not queued.
// Ports: clk, reset (sync, active-high), valid_in, alu_option, funct, src_a, src_b in;
//        alu_control, mdu_sel, mdu_result, busy, stall, illegal out.
// Config: MDU_DIV_EN enables div/divu; without it they decode as undefined functs.
module alu_muldiv_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [1:0]        alu_option,
    input  logic [5:0]        funct,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic              mdu_sel,
    output logic [WIDTH-1:0]  mdu_result,
    output logic              busy,
    output logic              stall,
    output logic              illegal
);
    dec_t             dec;
    logic             start;
    logic [WIDTH-1:0] hi, lo;

    always_comb begin
        dec      = '0;
        dec.ctrl = ALU_NOP;
        dec.op   = OP_MULT;
        case (alu_option)
            OPT_ADD: dec.ctrl = ALU_ADD;
            OPT_SUB: dec.ctrl = ALU_SUB;
            OPT_OR:  dec.ctrl = ALU_OR;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: dec.ctrl = ALU_ADD;
                    F_SUB, F_SUBU: dec.ctrl = ALU_SUB;
                    F_AND:         dec.ctrl = ALU_AND;
                    F_OR:          dec.ctrl = ALU_OR;
                    F_XOR:         dec.ctrl = ALU_XOR;
                    F_NOR:         dec.ctrl = ALU_NOR;
                    F_SLT:         dec.ctrl = ALU_SLT;
                    F_SLTU:        dec.ctrl = ALU_SLTU;
                    F_MFHI: begin
                        dec.mdu   = 1'b1;
                        dec.mf    = 1'b1;
                        dec.mf_hi = 1'b1;
                    end
                    F_MFLO: begin
                        dec.mdu = 1'b1;
                        dec.mf  = 1'b1;
                    end
                    F_MULT: begin
                        dec.mdu   = 1'b1;
                        dec.start = 1'b1;
                        dec.op    = OP_MULT;
                    end
                    F_MULTU: begin
                        dec.mdu   = 1'b1;
                        dec.start = 1'b1;
                        dec.op    = OP_MULTU;
                    end
`ifdef MDU_DIV_EN
                    F_DIV: begin
                        dec.mdu   = 1'b1;
                        dec.start = 1'b1;
                        dec.op    = OP_DIV;
                    end
                    F_DIVU: begin
                        dec.mdu   = 1'b1;
                        dec.start = 1'b1;
                        dec.op    = OP_DIVU;
                    end
`endif
                    default: dec.undef = 1'b1;
                endcase
            end
        endcase
    end

    assign alu_control = CTRL_W'(dec.ctrl);
    assign illegal     = valid_in & dec.undef;
    assign stall       = valid_in & busy & dec.mdu;
    assign start       = valid_in & dec.start & ~busy;
    assign mdu_sel     = valid_in & dec.mf;
    assign mdu_result  = mdu_sel ? (dec.mf_hi ? hi : lo) : '0;

    mdu_seq #(.WIDTH(WIDTH)) u_mdu_seq (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (dec.op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Purpose: self-checking bench for alu_muldiv_ctrl at WIDTH=32, decode table plus MDU sequences.
// Latency: expects busy for exactly 33 cycles per MDU op and HI/LO readable right after.
// Backpressure: exercises stall on mflo / second mult while busy and mid-operation reset.
module tb_alu_muldiv_ctrl;
    localparam int WIDTH = 32;

`ifdef MDU_DIV_EN
    localparam logic DIV_ILL = 1'b0;
`else
    localparam logic DIV_ILL = 1'b1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_in;
    logic [1:0]       alu_option;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a, src_b;
    logic [3:0]       alu_control;
    logic             mdu_sel;
    logic [WIDTH-1:0] mdu_result;
    logic             busy, stall, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv_ctrl #(.WIDTH(WIDTH), .CTRL_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .alu_option  (alu_option),
        .funct       (funct),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .mdu_sel     (mdu_sel),
        .mdu_result  (mdu_result),
        .busy        (busy),
        .stall       (stall),
        .illegal     (illegal)
    );

    typedef struct {
        logic       vld;
        logic [1:0] opt;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       ill;
        logic       sel;
    } dec_vec_t;

    dec_vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads HI then LO within one cycle, no clock edge in between.
    task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        valid_in   = 1'b1;
        alu_option = 2'b10;
        funct      = 6'b010000;
        #1;
        check({name, " mfhi_sel"}, 64'(mdu_sel), 64'd1);
        check({name, " HI"}, 64'(mdu_result), 64'(exp_hi));
        funct = 6'b010010;
        #1;
        check({name, " LO"}, 64'(mdu_result), 64'(exp_lo));
        valid_in = 1'b0;
    endtask

    task automatic run_mdu(input string name, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        valid_in   = 1'b1;
        alu_option = 2'b10;
        funct      = fn;
        src_a      = a;
        src_b      = b;
        #1;
        check({name, " issue_stall"}, 64'(stall), 64'd0);
        tick();
        valid_in = 1'b0;
        cycles   = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
        check({name, " busy_cycles"}, 64'(cycles), 64'd33);
        read_hilo(name, exp_hi, exp_lo);
    endtask

    initial begin
        int cycles;
        tbl[0]  = '{1'b1, 2'b00, 6'b000000, 4'b0010, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 6'b000000, 4'b0110, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b11, 6'b111111, 4'b0001, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 6'b111111, 4'b1111, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'b10, 6'b111111, 4'b1111, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'b10, 6'b100001, 4'b0010, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 6'b100011, 4'b0110, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 6'b100110, 4'b0011, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'b10, 6'b100111, 4'b0100, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'b10, 6'b101011, 4'b1000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 2'b10, 6'b010010, 4'b1111, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 2'b10, 6'b000101, 4'b1111, 1'b1, 1'b0};

        reset      = 1'b1;
        valid_in   = 1'b0;
        alu_option = 2'b00;
        funct      = 6'b000000;
        src_a      = '0;
        src_b      = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst illegal", 64'(illegal), 64'd0);
        check("rst mdu_sel", 64'(mdu_sel), 64'd0);
        check("rst mdu_result", 64'(mdu_result), 64'd0);
        check("rst alu_control", 64'(alu_control), 64'h2);
        read_hilo("rst", 32'h0, 32'h0);

        // Decode sweep.
        for (int i = 0; i < 15; i++) begin
            tick();
            valid_in   = tbl[i].vld;
            alu_option = tbl[i].opt;
            funct      = tbl[i].fn;
            #1;
            check($sformatf("dec[%0d] alu_control", i), 64'(alu_control), 64'(tbl[i].ctrl));
            check($sformatf("dec[%0d] illegal", i), 64'(illegal), 64'(tbl[i].ill));
            check($sformatf("dec[%0d] mdu_sel", i), 64'(mdu_sel), 64'(tbl[i].sel));
            check($sformatf("dec[%0d] stall", i), 64'(stall), 64'd0);
        end
        tick();
        valid_in = 1'b0;
        tick();

        run_mdu("mult", 6'b011000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        tick();
        run_mdu("multu", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        tick();

`ifdef MDU_DIV_EN
        run_mdu("div neg", 6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        tick();
        run_mdu("divu by0", 6'b011011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        tick();
        run_mdu("div min", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        tick();
`else
        valid_in   = 1'b1;
        alu_option = 2'b10;
        funct      = 6'b011010;
        src_a      = 32'hFFFFFFF9;
        src_b      = 32'h00000002;
        #1;
        check("nodiv illegal", 64'(illegal), 64'(DIV_ILL));
        check("nodiv alu_control", 64'(alu_control), 64'hF);
        tick();
        valid_in = 1'b0;
        check("nodiv busy", 64'(busy), 64'd0);
        read_hilo("nodiv", 32'hFFFFFFFE, 32'h00000001);
        tick();
`endif

        // Second mult then mflo held while busy: stalled, second mult dropped.
        valid_in   = 1'b1;
        alu_option = 2'b10;
        funct      = 6'b011000;
        src_a      = 32'd3;
        src_b      = 32'd5;
        tick();
        for (int i = 0; i < 20; i++) begin
            src_a = 32'd2;
            src_b = 32'd2;
            #1;
            check($sformatf("stall mult c%0d", i + 1), 64'(stall), 64'd1);
            tick();
        end
        funct  = 6'b010010;
        cycles = 0;
        while (busy && cycles < 100) begin
            #1;
            check($sformatf("stall mflo c%0d", cycles + 21), 64'(stall), 64'd1);
            cycles++;
            tick();
        end
        check("stall mflo cycles", 64'(cycles), 64'd13);
        #1;
        check("release stall", 64'(stall), 64'd0);
        check("release mdu_sel", 64'(mdu_sel), 64'd1);
        check("release mdu_result", 64'(mdu_result), 64'd15);
        tick();
        valid_in = 1'b0;
        tick();
        check("no second mult busy", 64'(busy), 64'd0);
        read_hilo("after stall", 32'h0, 32'd15);
        tick();

        // Reset in busy cycle 10 discards the op and clears HI/LO.
        valid_in   = 1'b1;
        alu_option = 2'b10;
        funct      = 6'b011000;
        src_a      = 32'hFFFFFFFD;
        src_b      = 32'h00000007;
        tick();
        valid_in = 1'b0;
        repeat (9) tick();
        check("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-reset busy", 64'(busy), 64'd0);
        read_hilo("post-reset", 32'h0, 32'h0);
        repeat (40) tick();
        check("post-reset idle", 64'(busy), 64'd0);
        read_hilo("post-reset late", 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
